// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int MMIO_SEL_BIT = 22;
    localparam int LED_W        = 6;

    // Request captured at grant time and replayed to the RAM in ISSUE.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        we;
        logic        data_side;
        logic        mmio;
    } req_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between the fetch and data requesters (grant=1 means data).
// Latency: combinational.
// Backpressure: none; the caller samples grant only when it can start a transaction.
module mem_arb_rr (
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    // On a tie the side that did not win last time takes the slot.
    assign grant = d_req & (~i_req | ~last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store; LED_MMIO_EN adds an LED register at d_addr[22].
// Latency: request sampled in IDLE cycle N, RAM strobe in N+1, ack pulse in N+2; one transaction per 3 cycles.
// Backpressure: requesters hold req and inputs until their ack; requests are only sampled in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wmask,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [LED_W-1:0]  leds
);

    state_t            state, state_nxt;
    req_t              lat;
    logic              last_grant;
    logic              grant;
    logic              mmio_hit;
    logic              led_wr;
    logic [LED_W-1:0]  leds_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    mem_arb_rr u_rr (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef LED_MMIO_EN
    assign mmio_hit = d_addr[MMIO_SEL_BIT];
`else
    assign mmio_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            lat        <= '0;
            leds_q     <= '1;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && (i_req || d_req)) begin
                last_grant    <= grant;
                lat.addr      <= grant ? d_addr : i_addr;
                lat.wdata     <= grant ? d_wdata : 32'd0;
                lat.wmask     <= grant ? d_wmask : 4'd0;
                lat.we        <= grant & d_we;
                lat.data_side <= grant;
                lat.mmio      <= grant & mmio_hit;
            end
            if (led_wr) leds_q <= ~lat.wdata[LED_W-1:0];
            if (i_ack)  i_rdata_q <= i_rdata;
            if (d_ack)  d_rdata_q <= d_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        led_wr    = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                ram_addr  = lat.addr[ADDR_W+1:2];
                ram_wdata = lat.wdata;
                ram_wmask = lat.we ? lat.wmask : 4'd0;
                ram_we    = lat.we & ~lat.mmio;
                ram_re    = ~lat.we & ~lat.mmio;
                led_wr    = lat.mmio & lat.we & lat.wmask[0];
            end
            ST_WAIT: begin
                state_nxt = ST_IDLE;
                // Reset in WAIT aborts the transaction, so the ack is suppressed too.
                if (!rst) begin
                    i_ack = ~lat.data_side;
                    d_ack = lat.data_side;
                    if (!lat.we) begin
                        if (lat.data_side)
                            d_rdata = lat.mmio ? {{(32-LED_W){1'b0}}, ~leds_q} : ram_rdata;
                        else
                            i_rdata = ram_rdata;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign leds = leds_q;

    // Address bits outside the RAM word range are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, lat.addr[31:ADDR_W+2], lat.addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

    localparam int AW = 10;
`ifdef LED_MMIO_EN
    localparam logic       MMIO_ON = 1'b1;
`else
    localparam logic       MMIO_ON = 1'b0;
`endif
    localparam logic       RAM_HI    = ~MMIO_ON;
    localparam logic [5:0] LED_AFTER = MMIO_ON ? 6'b010101 : 6'b111111;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_ack;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wmask;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wmask;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata;
    logic [5:0]    leds;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'd0;
        mem[4] <= 32'h00500093;
        ram_rdata <= 32'd0;
    end

    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Drive one request in an IDLE cycle (N) and check N, N+1, N+2 and the hold cycle after.
    task automatic txn(input string tag, input logic side, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                       input logic [9:0] exp_ra, input logic exp_ram, input logic [31:0] exp_rd);
        if (side) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wmask = mask;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk);
        chk({tag, ".ack_n"}, {30'd0, i_ack, d_ack}, 32'd0);
        chk({tag, ".strb_n"}, {30'd0, ram_we, ram_re}, 32'd0);
        @(negedge clk);
        chk({tag, ".ack_n1"}, {30'd0, i_ack, d_ack}, 32'd0);
        chk({tag, ".we"}, 32'(ram_we), 32'(we & exp_ram));
        chk({tag, ".re"}, 32'(ram_re), 32'(~we & exp_ram));
        chk({tag, ".addr"}, 32'(ram_addr), 32'(exp_ra));
        chk({tag, ".wmask"}, 32'(ram_wmask), 32'(we ? mask : 4'd0));
        chk({tag, ".wdata"}, ram_wdata, wdata);
        @(negedge clk);
        chk({tag, ".ack"}, {30'd0, i_ack, d_ack}, {30'd0, ~side, side});
        chk({tag, ".rdata"}, side ? d_rdata : i_rdata, exp_rd);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk({tag, ".ack_off"}, {30'd0, i_ack, d_ack}, 32'd0);
        chk({tag, ".hold"}, side ? d_rdata : i_rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst.strb", {30'd0, ram_we, ram_re}, 32'd0);
        chk("rst.irdata", i_rdata, 32'd0);
        chk("rst.drdata", d_rdata, 32'd0);
        chk("rst.leds", 32'(leds), 32'h3F);
        @(posedge clk); #1;
        rst = 1'b0;

        txn("fetch", 1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 10'd4, 1'b1, 32'h00500093);
        txn("store", 1'b1, 1'b1, 32'h80, 32'hDEADBEEF, 4'hF, 10'd32, 1'b1, 32'd0);
        txn("load", 1'b1, 1'b0, 32'h83, 32'd0, 4'd0, 10'd32, 1'b1, 32'hDEADBEEF);
        txn("pmask", 1'b1, 1'b1, 32'h80, 32'h12345678, 4'b0011, 10'd32, 1'b1, 32'hDEADBEEF);
        txn("load2", 1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 10'd32, 1'b1, 32'hDEAD5678);
        txn("fwrap", 1'b0, 1'b0, 32'h00001010, 32'd0, 4'd0, 10'd4, 1'b1, 32'h00500093);
        txn("mmst", 1'b1, 1'b1, 32'h00400000, 32'h2A, 4'b0001, 10'd0, RAM_HI, 32'hDEAD5678);
        chk("mm.leds", 32'(leds), 32'(LED_AFTER));
        txn("mmld", 1'b1, 1'b0, 32'h00400000, 32'd0, 4'd0, 10'd0, RAM_HI, 32'h2A);

        // Tie from reset: fetch first, then alternate, acks three cycles apart.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_wmask = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("tie.i%0d", k), 32'(i_ack), 32'(k % 6 == 2));
            chk($sformatf("tie.d%0d", k), 32'(d_ack), 32'(k % 6 == 5));
            chk($sformatf("tie.ird%0d", k), i_rdata, (k < 2) ? 32'd0 : 32'h00500093);
            chk($sformatf("tie.drd%0d", k), d_rdata, (k < 5) ? 32'd0 : 32'hDEAD5678);
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;

        // Reset while a write is in ISSUE.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'h11111111; d_wmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rmid.issue_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid.we", 32'(ram_we), 32'd0);
        chk("rmid.re", 32'(ram_re), 32'd0);
        chk("rmid.ack", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rmid.leds", 32'(leds), 32'h3F);
        chk("rmid.drdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rmid.noack%0d", k), {30'd0, i_ack, d_ack}, 32'd0);
        end
        @(posedge clk); #1;
        txn("post", 1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 10'd4, 1'b1, 32'h00500093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
